// File: rtl/mu0_pkg.sv
// mu0_pkg: shared state encoding and opcode constants for the MU0 sequencer and decoder
package mu0_pkg;
  typedef enum logic [2:0] {S_START, S_FETCH, S_EXEC1, S_EXEC2, S_PARK, S_HALT} state_t;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STO = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JGE = 4'b0101;
  localparam logic [3:0] OP_JNE = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
endpackage

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: MU0 fetch/execute phase FSM with instruction register, park/halt and retired-instruction counter (CLK/RST/RUN/MEM_Q/EXTRA in; phase strobes, OP/IR_ADDR, IDLE/HALTED, INSTR_CNT out)
module mu0_sequencer
  import mu0_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic [15:0] MEM_Q,
  input  logic        EXTRA,
  output logic        FETCH,
  output logic        EXEC1,
  output logic        EXEC2,
  output logic [3:0]  OP,
  output logic [11:0] IR_ADDR,
  output logic        IDLE,
  output logic        HALTED,
  output logic [15:0] INSTR_CNT
);
  state_t state, nxt, bnd;
  logic [15:0] ir;
  logic retire;
  assign OP = ir[15:12];
  assign IR_ADDR = ir[11:0];
  always_comb begin
    bnd = RUN ? S_FETCH : S_PARK;
    nxt = state;
    case (state)
      S_START, S_PARK: nxt = bnd;
      S_FETCH:         nxt = S_EXEC1;
      S_EXEC1:         nxt = ir[15:12] == OP_STP ? S_HALT : EXTRA ? S_EXEC2 : bnd;
      S_EXEC2:         nxt = bnd;
      default:         nxt = state;
    endcase
    retire = (state == S_EXEC1 && nxt != S_EXEC2) || state == S_EXEC2;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_START;
      ir        <= '0;
      INSTR_CNT <= '0;
      FETCH     <= 1'b0;
      EXEC1     <= 1'b0;
      EXEC2     <= 1'b0;
      IDLE      <= 1'b0;
      HALTED    <= 1'b0;
    end else begin
      state  <= nxt;
      ir     <= state == S_FETCH ? MEM_Q : ir;
      if (retire && INSTR_CNT != 16'hFFFF) INSTR_CNT <= INSTR_CNT + 16'd1;
      FETCH  <= nxt == S_FETCH;
      EXEC1  <= nxt == S_EXEC1;
      EXEC2  <= nxt == S_EXEC2;
      IDLE   <= nxt == S_PARK;
      HALTED <= nxt == S_HALT;
    end
  end
endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: directed self-checking bench for mu0_sequencer
module tb_mu0_sequencer;
  logic CLK = 1'b0, RST = 1'b1, RUN = 1'b0, EXTRA = 1'b0;
  logic [15:0] MEM_Q = '0;
  logic FETCH, EXEC1, EXEC2, IDLE, HALTED;
  logic [3:0] OP;
  logic [11:0] IR_ADDR;
  logic [15:0] INSTR_CNT;
  int total = 0, bad = 0;
  wire [4:0] st = {FETCH, EXEC1, EXEC2, IDLE, HALTED};
  localparam logic [4:0] ST_NONE = 5'b00000, ST_F = 5'b10000, ST_E1 = 5'b01000,
                         ST_E2 = 5'b00100, ST_PARK = 5'b00010, ST_HALT = 5'b00001;
  always #5 CLK = ~CLK;
  mu0_sequencer dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .MEM_Q(MEM_Q), .EXTRA(EXTRA),
    .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .OP(OP), .IR_ADDR(IR_ADDR),
    .IDLE(IDLE), .HALTED(HALTED), .INSTR_CNT(INSTR_CNT)
  );
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic test_reset();
    RST = 1'b1; RUN = 1'b1; EXTRA = 1'b1; MEM_Q = 16'hFFFF;
    tick(); tick();
    total++; if (st !== ST_NONE) begin bad++; $display("FAIL reset_strobes got=%b want=%b", st, ST_NONE); end
    total++; if ({OP, IR_ADDR} !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h want=0000", {OP, IR_ADDR}); end
    total++; if (INSTR_CNT !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h want=0000", INSTR_CNT); end
    RST = 1'b0; RUN = 1'b0; EXTRA = 1'b0;
    tick();
    total++; if (st !== ST_PARK) begin bad++; $display("FAIL start_to_park got=%b want=%b", st, ST_PARK); end
    RST = 1'b1; tick(); RST = 1'b0;
  endtask
  task automatic test_extra_instr();
    RUN = 1'b1; EXTRA = 1'b1;
    tick();
    total++; if (st !== ST_F) begin bad++; $display("FAIL s1_fetch got=%b want=%b", st, ST_F); end
    MEM_Q = 16'h2005; EXTRA = 1'b0;
    tick();
    total++; if (st !== ST_E1) begin bad++; $display("FAIL s1_exec1 got=%b want=%b", st, ST_E1); end
    total++; if (OP !== 4'h2 || IR_ADDR !== 12'h005) begin bad++; $display("FAIL s1_ir got=%h/%h want=2/005", OP, IR_ADDR); end
    EXTRA = 1'b1; MEM_Q = 16'hBEEF;
    tick();
    total++; if (st !== ST_E2) begin bad++; $display("FAIL s1_exec2 got=%b want=%b", st, ST_E2); end
    total++; if (OP !== 4'h2 || IR_ADDR !== 12'h005) begin bad++; $display("FAIL s1_ir_e2 got=%h/%h want=2/005", OP, IR_ADDR); end
    total++; if (INSTR_CNT !== 16'd0) begin bad++; $display("FAIL s1_cnt_e2 got=%0d want=0", INSTR_CNT); end
    EXTRA = 1'b0;
    tick();
    total++; if (st !== ST_F) begin bad++; $display("FAIL s1_refetch got=%b want=%b", st, ST_F); end
    total++; if (INSTR_CNT !== 16'd1) begin bad++; $display("FAIL s1_cnt got=%0d want=1", INSTR_CNT); end
  endtask
  task automatic test_short_instr();
    MEM_Q = 16'h1010; EXTRA = 1'b0;
    tick();
    total++; if (OP !== 4'h1 || IR_ADDR !== 12'h010) begin bad++; $display("FAIL s2_ir got=%h/%h want=1/010", OP, IR_ADDR); end
    MEM_Q = 16'hFFFF;
    tick();
    total++; if (st !== ST_F) begin bad++; $display("FAIL s2_no_exec2 got=%b want=%b", st, ST_F); end
    total++; if (INSTR_CNT !== 16'd2) begin bad++; $display("FAIL s2_cnt got=%0d want=2", INSTR_CNT); end
    total++; if (OP !== 4'h1 || IR_ADDR !== 12'h010) begin bad++; $display("FAIL s2_ir_hold got=%h/%h want=1/010", OP, IR_ADDR); end
  endtask
  task automatic test_park();
    MEM_Q = 16'h3123;
    tick();
    EXTRA = 1'b1; RUN = 1'b0;
    tick();
    total++; if (st !== ST_E2) begin bad++; $display("FAIL s4_exec2 got=%b want=%b", st, ST_E2); end
    EXTRA = 1'b0;
    tick();
    total++; if (st !== ST_PARK) begin bad++; $display("FAIL s4_park got=%b want=%b", st, ST_PARK); end
    total++; if (INSTR_CNT !== 16'd3) begin bad++; $display("FAIL s4_cnt got=%0d want=3", INSTR_CNT); end
    EXTRA = 1'b1;
    tick();
    total++; if (st !== ST_PARK || INSTR_CNT !== 16'd3) begin bad++; $display("FAIL s4_park_hold got=%b/%0d want=%b/3", st, INSTR_CNT, ST_PARK); end
    RUN = 1'b1; EXTRA = 1'b0;
    tick();
    total++; if (st !== ST_F) begin bad++; $display("FAIL s4_resume got=%b want=%b", st, ST_F); end
  endtask
  task automatic test_halt();
    MEM_Q = 16'h7000;
    tick();
    total++; if (OP !== 4'h7 || st !== ST_E1) begin bad++; $display("FAIL s3_exec1 got=%h/%b want=7/%b", OP, st, ST_E1); end
    EXTRA = 1'b1;
    tick();
    total++; if (st !== ST_HALT) begin bad++; $display("FAIL s3_halt got=%b want=%b", st, ST_HALT); end
    total++; if (INSTR_CNT !== 16'd4) begin bad++; $display("FAIL s3_cnt got=%0d want=4", INSTR_CNT); end
    MEM_Q = 16'h2222;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (st !== ST_HALT || INSTR_CNT !== 16'd4 || OP !== 4'h7) begin bad++; $display("FAIL s3_hold%0d got=%b/%0d/%h want=%b/4/7", i, st, INSTR_CNT, OP, ST_HALT); end
    end
    EXTRA = 1'b0;
  endtask
  task automatic test_reset_midway();
    RST = 1'b1;
    tick();
    total++; if (st !== ST_NONE || INSTR_CNT !== 16'd0 || {OP, IR_ADDR} !== 16'h0) begin bad++; $display("FAIL s5_halt_rst got=%b/%0d/%h want=%b/0/0000", st, INSTR_CNT, {OP, IR_ADDR}, ST_NONE); end
    RST = 1'b0; RUN = 1'b1;
    tick();
    MEM_Q = 16'h2ABC;
    tick();
    EXTRA = 1'b1;
    tick();
    total++; if (st !== ST_E2) begin bad++; $display("FAIL s5_exec2 got=%b want=%b", st, ST_E2); end
    RST = 1'b1;
    tick();
    total++; if (st !== ST_NONE || INSTR_CNT !== 16'd0 || {OP, IR_ADDR} !== 16'h0) begin bad++; $display("FAIL s5_exec2_rst got=%b/%0d/%h want=%b/0/0000", st, INSTR_CNT, {OP, IR_ADDR}, ST_NONE); end
    RST = 1'b0; EXTRA = 1'b0;
  endtask
  task automatic test_saturate();
    logic [15:0] want;
    RUN = 1'b1; MEM_Q = 16'h1000; EXTRA = 1'b0;
    tick();
    force dut.INSTR_CNT = 16'hFFFD;
    #1;
    release dut.INSTR_CNT;
    want = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      tick(); tick();
      want = want == 16'hFFFF ? want : want + 16'd1;
      total++; if (INSTR_CNT !== want) begin bad++; $display("FAIL s6_sat%0d got=%h want=%h", i, INSTR_CNT, want); end
    end
  endtask
  initial begin
    @(negedge CLK);
    test_reset();
    test_extra_instr();
    test_short_instr();
    test_park();
    test_halt();
    test_reset_midway();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mu0_sequencer.md
MU0_SEQUENCER -- requirements
Module: mu0_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port RST, input, 1, reset: synchronous and active-high.
REQ-003 SHALL have port RUN, input, 1, level enable; low parks the sequencer at the next instruction boundary.
REQ-004 SHALL have port MEM_Q, input, 16, RAM read data, valid during FETCH.
REQ-005 SHALL have port EXTRA, input, 1, decoder request for EXEC2, sampled in EXEC1.
REQ-006 SHALL have port FETCH, output, 1, one-hot phase strobe.
REQ-007 SHALL have port EXEC1, output, 1, one-hot phase strobe.
REQ-008 SHALL have port EXEC2, output, 1, one-hot phase strobe.
REQ-009 SHALL have port OP, output, 4 [15:12], instruction-register opcode field.
REQ-010 SHALL have port IR_ADDR, output, 12, instruction-register operand field.
REQ-011 SHALL have port IDLE, output, 1, parked at a boundary because RUN is low.
REQ-012 SHALL have port HALTED, output, 1, STP executed; sticky.
REQ-013 SHALL have port INSTR_CNT, output, 16, count of retired instructions.

Function
REQ-014 SHALL implement states START, FETCH, EXEC1, EXEC2, PARK, HALT; FETCH/EXEC1/EXEC2 outputs high only in the same-named state; in START, PARK and HALT all three strobes are low.
REQ-015 SHALL transition START -> FETCH if RUN = 1, else START -> PARK.
REQ-016 SHALL transition FETCH -> EXEC1 unconditionally, loading the IR with MEM_Q on that edge.
REQ-017 SHALL keep OP = IR[15:12] and IR_ADDR = IR[11:0], registered and stable through EXEC1 and EXEC2.
REQ-018 SHALL transition EXEC1 to HALT when OP = 4'b0111 (STP), regardless of EXTRA.
REQ-019 SHALL otherwise transition EXEC1 -> EXEC2 when EXTRA = 1, else EXEC1 to the instruction boundary.
REQ-020 SHALL transition EXEC2 to the instruction boundary unconditionally.
REQ-021 Instruction boundary: SHALL go to FETCH if RUN = 1, else to PARK.
REQ-022 SHALL transition PARK -> FETCH when RUN = 1 and stay in PARK otherwise; IDLE = 1 only in PARK.
REQ-023 SHALL make HALT absorbing (only RST leaves it), with HALTED = 1 there.
REQ-024 SHALL ignore RUN while mid-instruction (EXEC1/EXEC2); an instruction once fetched always completes.
REQ-025 SHALL increment INSTR_CNT by 1 on each transition to the instruction boundary and on entry to HALT (STP counts).
REQ-026 SHALL saturate INSTR_CNT at 16'hFFFF; it does not wrap.
REQ-027 SHALL not load the IR in any state other than FETCH.
REQ-028 SHALL take EXTRA from EXEC1 only; EXTRA in other states is ignored.

Reset
REQ-029 RST = 1 at a rising edge SHALL force state START, IR = 16'h0000, INSTR_CNT = 0, HALTED = 0, IDLE = 0, and FETCH = EXEC1 = EXEC2 = 0, from any state including mid-instruction and HALT.
REQ-030 RST SHALL take priority over every other input on the same edge.

Structure
REQ-031 SHALL place the state encoding and the STP opcode constant (4'b0111) in shared package mu0_pkg, which the decoder also uses for opcode constants.
REQ-032 SHALL be one module with no sub-modules; the IR and counter are inline registers.

Verification
REQ-033 Scenario 1: RST, then RUN = 1, MEM_Q = 16'h2005 in FETCH, EXTRA = 1 in EXEC1 -> sequence START, FETCH, EXEC1, EXEC2, FETCH; OP = 4'h2, IR_ADDR = 12'h005; INSTR_CNT = 1.
REQ-034 Scenario 2: MEM_Q = 16'h1010, EXTRA = 0 -> FETCH, EXEC1, FETCH; no EXEC2 cycle; INSTR_CNT increments by 1.
REQ-035 Scenario 3: MEM_Q = 16'h7000 with EXTRA = 1 -> HALT after EXEC1; HALTED = 1 and held for 20 cycles with RUN = 1; INSTR_CNT increments once.
REQ-036 Scenario 4: RUN dropped during EXEC1 of an EXTRA = 1 instruction -> EXEC2 still occurs, then PARK with IDLE = 1; RUN = 1 -> FETCH on the next cycle.
REQ-037 Scenario 5: RST asserted during EXEC2 and during HALT -> next cycle is START with all outputs at reset values.
REQ-038 Scenario 6: preload INSTR_CNT near saturation by running 65,536 or more instructions (or a forced value in simulation) -> INSTR_CNT holds at 16'hFFFF.
